// File: rtl/sum_fact_bcd_conv.sv
// sum_fact_bcd_conv: takes one binary sum-of-factorials result per
// valid/ack handshake, converts it to packed BCD by double dabble
// (one add-3/shift step per cycle) and offers it on a valid/ready port.
module sum_fact_bcd_conv #(
  parameter int unsigned IN_W   = 13,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  res_valid,
  input  logic [IN_W-1:0]       res_data,
  output logic                  res_ack,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_data,
  input  logic                  bcd_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      conv_count
);

  localparam int unsigned BC_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] bcd_sr;
  logic [IN_W-1:0]     bin_sr;
  logic [BC_W-1:0]     bit_cnt;

  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_nxt;
  logic [IN_W-1:0]     bin_nxt;

  // One double-dabble step: add 3 to every digit >= 5, then shift the
  // combined {BCD, binary} register left so the binary MSB enters digit 0.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_sr} << 1;
  end

  // Capture strobe is only offered while idle, so upstream can never be
  // acked while a result is still being converted or delivered.
  assign res_ack = (state == IDLE) && res_valid;

  // Control FSM and datapath registers; all outputs besides res_ack are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bcd_sr     <= '0;
      bin_sr     <= '0;
      bit_cnt    <= '0;
      conv_count <= '0;
      bcd_valid  <= 1'b0;
      bcd_data   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (res_valid) begin
            bin_sr  <= res_data;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd_sr  <= bcd_nxt;
          bin_sr  <= bin_nxt;
          bit_cnt <= bit_cnt + 1'b1;
          // Last shift: publish the finished digits on the same edge.
          if (bit_cnt == BC_W'(IN_W - 1)) begin
            bcd_valid <= 1'b1;
            bcd_data  <= bcd_nxt;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bcd_ready) begin
            bcd_valid  <= 1'b0;
            bcd_data   <= '0;
            busy       <= 1'b0;
            conv_count <= conv_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_fact_bcd_conv.sv
// Directed bench for sum_fact_bcd_conv: hand-computed BCD values, latency,
// backpressure, async reset mid-conversion and counter wrap.
module tb_sum_fact_bcd_conv;

  logic        clk;
  logic        reset;
  logic        res_valid;
  logic [12:0] res_data;
  logic        res_ack;
  logic        bcd_valid;
  logic [15:0] bcd_data;
  logic        bcd_ready;
  logic        busy;
  logic [7:0]  conv_count;

  int unsigned vectors;
  int unsigned miscompares;
  logic [7:0]  exp_cnt;

  sum_fact_bcd_conv #(
    .IN_W   (13),
    .DIGITS (4),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ack    (res_ack),
    .bcd_valid  (bcd_valid),
    .bcd_data   (bcd_data),
    .bcd_ready  (bcd_ready),
    .busy       (busy),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle. Presents v, follows it
  // through 13 shift cycles, holds ready low for 'stall' cycles while a new
  // res_valid is offered, then accepts the result.
  task automatic convert(input logic [12:0] v, input logic [15:0] exp_bcd,
                         input int unsigned stall);
    res_valid = 1'b1;
    res_data  = v;
    #1;
    check("ack_in_idle", {31'd0, res_ack}, 32'd1);
    @(posedge clk);                       // E0: capture
    @(negedge clk);
    res_valid = 1'b0;
    #1;
    check("ack_after_capture", {31'd0, res_ack}, 32'd0);
    check("busy_conv", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 12; k++) begin   // after E1..E12
      @(negedge clk);
      check("valid_early", {31'd0, bcd_valid}, 32'd0);
    end
    @(negedge clk);                       // after E13
    check("valid_at_13", {31'd0, bcd_valid}, 32'd1);
    check("bcd_data", {16'd0, bcd_data}, {16'd0, exp_bcd});
    for (int s = 0; s < int'(stall); s++) begin
      bcd_ready = 1'b0;
      res_valid = 1'b1;
      res_data  = 13'd77;
      #1;
      check("stall_ack", {31'd0, res_ack}, 32'd0);
      @(negedge clk);
      check("stall_valid", {31'd0, bcd_valid}, 32'd1);
      check("stall_data", {16'd0, bcd_data}, {16'd0, exp_bcd});
    end
    res_valid = 1'b0;
    bcd_ready = 1'b1;
    @(posedge clk);                       // accept edge
    exp_cnt = exp_cnt + 8'd1;
    @(negedge clk);
    check("valid_dropped", {31'd0, bcd_valid}, 32'd0);
    check("data_cleared", {16'd0, bcd_data}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("conv_count", {24'd0, conv_count}, {24'd0, exp_cnt});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 8'd0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 8'd0;
    reset       = 1'b1;
    res_valid   = 1'b0;
    res_data    = '0;
    bcd_ready   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, res_ack}, 32'd0);
    check("rst_valid", {31'd0, bcd_valid}, 32'd0);
    check("rst_data", {16'd0, bcd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {24'd0, conv_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_no_valid", {31'd0, bcd_valid}, 32'd0);
    check("idle_no_busy", {31'd0, busy}, 32'd0);

    // Maximum engine result
    convert(13'd5913, 16'h5913, 0);

    // Back-to-back with ready tied high
    bcd_ready = 1'b1;
    convert(13'd1, 16'h0001, 0);
    convert(13'd33, 16'h0033, 0);

    // Backpressure: 20 stalled cycles
    bcd_ready = 1'b0;
    convert(13'd153, 16'h0153, 20);

    // Bounds
    convert(13'd0, 16'h0000, 0);
    convert(13'd8191, 16'h8191, 0);
    bcd_ready = 1'b0;

    // Reset during shift 6 of 5913
    res_valid = 1'b1;
    res_data  = 13'd5913;
    @(posedge clk);                       // E0
    @(negedge clk);
    res_valid = 1'b0;
    repeat (6) @(negedge clk);            // after E6
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
    check("midrst_data", {16'd0, bcd_data}, 32'd0);
    check("midrst_count", {24'd0, conv_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 8'd0;
    bcd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("midrst_no_valid", {31'd0, bcd_valid}, 32'd0);
    end
    bcd_ready = 1'b0;
    convert(13'd9, 16'h0009, 0);

    // Counter wrap from a clean reset
    do_reset();
    for (int n = 0; n < 256; n++) begin
      convert(13'd3, 16'h0003, 0);
    end
    check("wrap_count_zero", {24'd0, conv_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
